ysyx_24110006_icache_sa: RTL

Parametrised N-way set-associative instruction cache. It sits between IFU fetch and the AXI4 read master, and is the successor to the 4-line direct-mapped icache. It adds configurable ways, sets and line size, per-set round-robin replacement, i_flush (fence.i) invalidation, AXI read-error reporting and 32-bit hit/miss counters. The uncached SRAM region (addr[31:24]==UNCACHED_HI) bypasses the arrays with single-beat reads.

---
 rtl/ysyx_24110006_icache_sa_pkg.sv | 33 +++
 rtl/ysyx_24110006_icache_sa_if.sv | 28 ++
 rtl/ysyx_24110006_icache_sa_way.sv | 63 ++++++
 rtl/ysyx_24110006_icache_sa.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110006_icache_sa_pkg.sv
// Shared types and constants for the set-associative instruction cache.
// Also holds the helpers that derive the address-field widths from the geometry.
package ysyx_24110006_icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_AR,
        S_REFILL_R,
        S_RESP,
        S_BYP_AR,
        S_BYP_R,
        S_FLUSH
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned line_words, input int unsigned sets);
        return 32 - off_w(line_words) - idx_w(sets);
    endfunction

endpackage

// File: rtl/ysyx_24110006_icache_sa_if.sv
// AXI4 read-address / read-data channels between the icache and its memory port.
interface ysyx_24110006_icache_sa_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rready;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, rready,
        input  arready, rdata, rvalid, rresp, rid, rlast
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
        output arready, rdata, rvalid, rresp, rid, rlast
    );

endinterface

// File: rtl/ysyx_24110006_icache_sa_way.sv
// One cache way: per-set valid bit and tag, line data, parallel tag compare.
// Lookup and write share the set index taken from the latched fetch address.
module ysyx_24110006_icache_way #(
    parameter int unsigned SETS       = 4,
    parameter int unsigned LINE_WORDS = 2,
    parameter int unsigned TAG_W      = 27,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned WOFF_W     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  lk_tag,
    input  logic [WOFF_W-1:0] lk_off,
    output logic              hit,
    output logic [31:0]       lk_word,
    output logic              lk_valid,
    input  logic              wr_en,
    input  logic [WOFF_W-1:0] wr_off,
    input  logic [31:0]       wr_data,
    input  logic              set_valid,
    input  logic              clr_valid,
    input  logic [TAG_W-1:0]  set_tag
);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS*LINE_WORDS];

    always_comb begin
        valid_d = valid_q;
        if (flush_clr) begin
            valid_d = '0;
        end else if (clr_valid) begin
            valid_d[idx] = 1'b0;
        end else if (set_valid) begin
            valid_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (set_valid) begin
            tag_mem[idx] <= set_tag;
        end
        if (wr_en) begin
            data_mem[{idx, wr_off}] <= wr_data;
        end
    end

    assign lk_valid = valid_q[idx];
    assign hit      = lk_valid && (tag_mem[idx] == lk_tag);
    assign lk_word  = data_mem[{idx, lk_off}];

endmodule

// File: rtl/ysyx_24110006_icache_sa.sv
// N-way set-associative instruction cache with round-robin replacement,
// fence.i flush, uncached bypass window and hit/miss counters.
module ysyx_24110006_icache_sa
    import ysyx_24110006_icache_pkg::*;
#(
    parameter int unsigned WAYS        = 2,
    parameter int unsigned SETS        = 4,
    parameter int unsigned LINE_WORDS  = 2,
    parameter logic [7:0]  UNCACHED_HI = 8'h0f,
    parameter logic [3:0]  AXI_ID      = 4'h0
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_pc,
    input  logic        i_valid,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic        o_err,
    input  logic        i_flush,
    output logic        o_flush_done,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt,
    ysyx_24110006_icache_sa_if.master axi
);

    localparam int unsigned OFF_W  = off_w(LINE_WORDS);
    localparam int unsigned IDX_W  = idx_w(SETS);
    localparam int unsigned TAG_W  = tag_w(LINE_WORDS, SETS);
    localparam int unsigned WOFF_W = OFF_W - 2;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       cap_inst_q, cap_inst_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              cap_err_q, cap_err_d;
    logic              line_err_q, line_err_d;
    logic              flush_done_q, flush_done_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [WOFF_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  rr_q [SETS];
    logic [WAY_W-1:0]  rr_d [SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WOFF_W-1:0] woff;
    logic [WAYS-1:0]   hit_w, vld_w;
    logic [31:0]       word_w [WAYS];
    logic              hit_any, beat_err;
    logic [31:0]       hit_word;
    logic [WAY_W-1:0]  victim_sel, wr_way;
    logic              found_inv;
    logic              wr_en, set_valid, clr_valid, flush_clr;
    logic              unused_rid;

    assign woff = pc_q[OFF_W-1:2];
    assign idx  = pc_q[OFF_W+IDX_W-1:OFF_W];
    assign tag  = pc_q[31:OFF_W+IDX_W];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        ysyx_24110006_icache_way #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W),
            .IDX_W(IDX_W), .WOFF_W(WOFF_W)
        ) u_way (
            .clk(i_clock), .rst_n(i_reset_n), .flush_clr(flush_clr),
            .idx(idx), .lk_tag(tag), .lk_off(woff),
            .hit(hit_w[g]), .lk_word(word_w[g]), .lk_valid(vld_w[g]),
            .wr_en(wr_en && (wr_way == WAY_W'(g))), .wr_off(beat_q), .wr_data(axi.rdata),
            .set_valid(set_valid && (wr_way == WAY_W'(g))),
            .clr_valid(clr_valid && (wr_way == WAY_W'(g))),
            .set_tag(tag)
        );
    end

    // Lowest invalid way wins; the round-robin pointer is used only when the set is full.
    always_comb begin
        hit_any    = 1'b0;
        hit_word   = '0;
        victim_sel = rr_q[idx];
        found_inv  = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (hit_w[w]) begin
                hit_any  = 1'b1;
                hit_word = word_w[w];
            end
            if (!vld_w[w] && !found_inv) begin
                found_inv  = 1'b1;
                victim_sel = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        cap_inst_d   = cap_inst_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        valid_d      = 1'b0;
        err_d        = err_q;
        cap_err_d    = cap_err_q;
        line_err_d   = line_err_q;
        flush_done_d = 1'b0;
        victim_d     = victim_q;
        beat_d       = beat_q;
        rr_d         = rr_q;
        wr_way       = victim_q;
        wr_en        = 1'b0;
        set_valid    = 1'b0;
        clr_valid    = 1'b0;
        flush_clr    = 1'b0;
        beat_err     = (axi.rresp != RESP_OKAY);

        case (state_q)
            S_IDLE: begin
                // A response or flush-done cycle never accepts new work.
                if (!valid_q && !flush_done_q) begin
                    if (i_flush) begin
                        state_d = S_FLUSH;
                    end else if (i_valid) begin
                        pc_d    = i_pc;
                        state_d = (i_pc[31:24] == UNCACHED_HI) ? S_BYP_AR : S_LOOKUP;
                    end
                end
            end
            S_FLUSH: begin
                flush_clr    = 1'b1;
                rr_d         = '{default: '0};
                flush_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    inst_d    = hit_word;
                    err_d     = 1'b0;
                    valid_d   = 1'b1;
                    hit_cnt_d = hit_cnt_q + 32'd1;
                    state_d   = S_IDLE;
                end else begin
                    // The victim is invalidated up front so a partly overwritten line never hits.
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    victim_d   = victim_sel;
                    wr_way     = victim_sel;
                    clr_valid  = 1'b1;
                    beat_d     = '0;
                    line_err_d = 1'b0;
                    cap_err_d  = 1'b0;
                    state_d    = S_REFILL_AR;
                end
            end
            S_REFILL_AR: begin
                if (axi.arready) begin
                    state_d = S_REFILL_R;
                end
            end
            S_REFILL_R: begin
                if (axi.rvalid) begin
                    wr_en      = 1'b1;
                    beat_d     = beat_q + WOFF_W'(1);
                    line_err_d = line_err_q | beat_err;
                    if (beat_q == woff) begin
                        cap_inst_d = axi.rdata;
                        cap_err_d  = beat_err;
                    end
                    if (axi.rlast) begin
                        beat_d  = '0;
                        state_d = S_RESP;
                        if (!(line_err_q || beat_err)) begin
                            set_valid = 1'b1;
                            if (WAYS > 1) begin
                                rr_d[idx] = rr_q[idx] + WAY_W'(1);
                            end
                        end
                    end
                end
            end
            S_RESP: begin
                inst_d  = cap_inst_q;
                err_d   = cap_err_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            S_BYP_AR: begin
                if (axi.arready) begin
                    state_d = S_BYP_R;
                end
            end
            S_BYP_R: begin
                if (axi.rvalid) begin
                    inst_d  = axi.rdata;
                    err_d   = beat_err;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            inst_q       <= '0;
            cap_inst_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            cap_err_q    <= 1'b0;
            line_err_q   <= 1'b0;
            flush_done_q <= 1'b0;
            victim_q     <= '0;
            beat_q       <= '0;
            rr_q         <= '{default: '0};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            cap_inst_q   <= cap_inst_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            cap_err_q    <= cap_err_d;
            line_err_q   <= line_err_d;
            flush_done_q <= flush_done_d;
            victim_q     <= victim_d;
            beat_q       <= beat_d;
            rr_q         <= rr_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_inst       = inst_q;
    assign o_err        = err_q;
    assign o_flush_done = flush_done_q;
    assign o_hit_cnt    = hit_cnt_q;
    assign o_miss_cnt   = miss_cnt_q;

    assign axi.arvalid = (state_q == S_REFILL_AR) || (state_q == S_BYP_AR);
    assign axi.araddr  = (state_q == S_BYP_AR) ? pc_q : {pc_q[31:OFF_W], {OFF_W{1'b0}}};
    assign axi.arlen   = (state_q == S_BYP_AR) ? 8'd0 : 8'(LINE_WORDS - 1);
    assign axi.arburst = (state_q == S_BYP_AR) ? BURST_FIXED : BURST_INCR;
    assign axi.arsize  = SIZE_4B;
    assign axi.arid    = AXI_ID;
    assign axi.rready  = 1'b1;
    assign unused_rid  = ^axi.rid;

endmodule
